// File: rtl/gcd_ctrl4.sv
// Euclid-by-subtraction GCD controller driving an external combinational subtractor.
// One subtraction per RUN cycle; result and iteration count are returned with a one-cycle done pulse.
//
// state | meaning
// IDLE  | ready=1, waiting for start; result/iters hold the last answer
// RUN   | one subtraction per edge until x==0, y==0 or x==y
// DONE  | done=1 for one cycle, then back to IDLE (start ignored here)
module gcd_ctrl4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] iters,
    output logic [WIDTH-1:0] sub_a,
    output logic [WIDTH-1:0] sub_b,
    input  logic [WIDTH-1:0] sub_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             x_gt_y;

    // The larger operand is always the minuend, so the difference never wraps.
    assign x_gt_y = (x > y);
    assign sub_a  = x_gt_y ? x : y;
    assign sub_b  = x_gt_y ? y : x;
    assign ready  = (state == IDLE);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            x      <= '0;
            y      <= '0;
            result <= '0;
            iters  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x     <= a_in;
                        y     <= b_in;
                        iters <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if ((x == '0) || (y == '0)) begin
                        result <= x | y;
                        state  <= DONE;
                    end else if (x == y) begin
                        result <= x;
                        state  <= DONE;
                    end else if (x_gt_y) begin
                        x     <= sub_out;
                        iters <= iters + WIDTH'(1);
                    end else begin
                        y     <= sub_out;
                        iters <= iters + WIDTH'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_ctrl4.sv
// Directed bench for gcd_ctrl4 with a behavioural subtractor, a result scoreboard
// and a queue of expected subtractor operand pairs per RUN cycle.
module tb_gcd_ctrl4;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] iters;
    logic [WIDTH-1:0] sub_a;
    logic [WIDTH-1:0] sub_b;
    logic [WIDTH-1:0] sub_out;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] it;
        int               lat;
        string            tag;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] sa;
        logic [WIDTH-1:0] sb;
    } sub_t;

    exp_t             sb_q[$];
    sub_t             sub_q[$];
    int               n_cmp;
    int               n_err;
    logic [WIDTH-1:0] last_res;

    gcd_ctrl4 #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .ready   (ready),
        .done    (done),
        .result  (result),
        .iters   (iters),
        .sub_a   (sub_a),
        .sub_b   (sub_b),
        .sub_out (sub_out)
    );

    assign sub_out = sub_a - sub_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] res, input logic [WIDTH-1:0] it,
                            input int lat, input string tag);
        exp_t e;
        e.res = res;
        e.it  = it;
        e.lat = lat;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic push_sub(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sbv);
        sub_t s;
        s.sa = sa;
        s.sb = sbv;
        sub_q.push_back(s);
    endtask

    // Called right after the accepting edge; the first negedge is cycle 1.
    task automatic wait_done(input string tag);
        int   lat;
        bit   seen;
        exp_t e;
        sub_t s;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            check({tag, "_ready_busy"}, 32'(ready), 32'd0);
            check({tag, "_result_held"}, 32'(result), 32'(last_res));
            if (sub_q.size() > 0) begin
                s = sub_q.pop_front();
                check({tag, "_sub_a"}, 32'(sub_a), 32'(s.sa));
                check({tag, "_sub_b"}, 32'(sub_b), 32'(s.sb));
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        sub_q.delete();
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (seen) begin
                check({e.tag, "_result"}, 32'(result), 32'(e.res));
                check({e.tag, "_iters"}, 32'(iters), 32'(e.it));
                check({e.tag, "_latency"}, 32'(lat), 32'(e.lat));
                check({e.tag, "_ready_in_done"}, 32'(ready), 32'd0);
                last_res = e.res;
                @(negedge clk);
                check({e.tag, "_done_pulse"}, 32'(done), 32'd0);
                check({e.tag, "_ready_back"}, 32'(ready), 32'd1);
                check({e.tag, "_result_after"}, 32'(result), 32'(e.res));
            end
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] res, input logic [WIDTH-1:0] it,
                          input int lat, input string tag);
        push_exp(res, it, lat, tag);
        @(negedge clk);
        check({tag, "_ready_idle"}, 32'(ready), 32'd1);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(tag);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        last_res = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a_in     = '0;
        b_in     = '0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_iters", 32'(iters), 32'd0);
        check("rst_sub_a", 32'(sub_a), 32'd0);
        check("rst_sub_b", 32'(sub_b), 32'd0);

        push_sub(4'd12, 4'd8);
        push_sub(4'd8, 4'd4);
        push_sub(4'd4, 4'd4);
        run_op(4'd12, 4'd8, 4'd4, 4'd2, 4, "gcd_12_8");

        for (int k = 15; k >= 2; k--) push_sub(4'(k), 4'd1);
        push_sub(4'd1, 4'd1);
        run_op(4'd15, 4'd1, 4'd1, 4'd14, 16, "gcd_15_1");

        push_sub(4'd7, 4'd7);
        run_op(4'd7, 4'd7, 4'd7, 4'd0, 2, "gcd_7_7");

        run_op(4'd0, 4'd9, 4'd9, 4'd0, 2, "gcd_0_9");
        run_op(4'd0, 4'd0, 4'd0, 4'd0, 2, "gcd_0_0");

        // start pulsed during RUN must be ignored; then held high through DONE
        push_exp(4'd3, 4'd2, 4, "gcd_9_6");
        push_sub(4'd9, 4'd6);
        push_sub(4'd6, 4'd3);
        push_sub(4'd3, 4'd3);
        @(negedge clk);
        check("gcd_9_6_ready_idle", 32'(ready), 32'd1);
        start = 1'b1;
        a_in  = 4'd9;
        b_in  = 4'd6;
        @(posedge clk);
        #1;
        fork
            wait_done("gcd_9_6");
            begin
                start = 1'b1;
                a_in  = 4'd1;
                b_in  = 4'd1;
                @(posedge clk);
                #1;
                start = 1'b0;
                @(posedge clk);
                #1;
                start = 1'b1;
                a_in  = 4'd12;
                b_in  = 4'd8;
            end
        join
        push_exp(4'd4, 4'd2, 4, "gcd_hold_12_8");
        push_sub(4'd12, 4'd8);
        push_sub(4'd8, 4'd4);
        push_sub(4'd4, 4'd4);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hold_accept_ready", 32'(ready), 32'd0);
        check("hold_result_kept", 32'(result), 32'd3);
        wait_done("gcd_hold_12_8");

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        start = 1'b1;
        a_in  = 4'd15;
        b_in  = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("pre_abort_ready", 32'(ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_iters", 32'(iters), 32'd0);
        check("abort_sub_a", 32'(sub_a), 32'd0);
        check("abort_sub_b", 32'(sub_b), 32'd0);
        last_res = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_idle", 32'(ready), 32'd1);
        end

        push_sub(4'd6, 4'd4);
        push_sub(4'd4, 4'd2);
        push_sub(4'd2, 4'd2);
        run_op(4'd6, 4'd4, 4'd2, 4'd2, 4, "gcd_6_4");

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
